// File: rtl/pipeline_fetch_queue.sv
// Instruction fetch front end: PC generation, synchronous instruction-memory
// reads, and a small FIFO of {instruction, PC} entries toward decode.
// It stops fetching after a HALT opcode (2'b11) and restarts on redirect.
module pipeline_fetch_queue #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [INSTR_W-1:0]       dec_instr,
  output logic [ADDR_W-1:0]        dec_pc,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_EXT = DEPTH[CNT_W:0];
  localparam logic [1:0]     OP_HALT   = 2'b11;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e              st_q, st_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   issue_pc_q, issue_pc_d;
  logic                inflight_q, inflight_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [INSTR_W-1:0]  hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0]   hold_pc_q, hold_pc_d;
  logic [INSTR_W-1:0]  fifo_instr_q [DEPTH];
  logic [ADDR_W-1:0]   fifo_pc_q [DEPTH];

  logic                resp_live;
  logic                resp_halt;
  logic                push;
  logic                pop;
  logic [CNT_W:0]      occupancy;

  // Handshake, issue decision and head presentation.
  // A returning HALT word blocks issue in its own cycle so nothing is
  // fetched past the HALT instruction.
  always_comb begin
    resp_live = inflight_q && !redirect;
    resp_halt = resp_live && (imem_rdata[INSTR_W-1 -: 2] == OP_HALT);
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    imem_req  = reset && (st_q == ST_RUN) && !redirect && !resp_halt &&
                (occupancy < DEPTH_EXT);
    imem_addr = pc_q;
    dec_valid = (count_q != {CNT_W{1'b0}});
    pop       = dec_valid && dec_ready;
    push      = resp_live;
    halted    = (st_q == ST_HALT);
    count     = count_q;
    if (dec_valid) begin
      dec_instr = fifo_instr_q[rd_ptr_q];
      dec_pc    = fifo_pc_q[rd_ptr_q];
    end else begin
      dec_instr = hold_instr_q;
      dec_pc    = hold_pc_q;
    end
  end

  // Next-state logic for PC, fetch state, in-flight tracking and FIFO pointers.
  always_comb begin
    st_d         = st_q;
    pc_d         = pc_q;
    issue_pc_d   = issue_pc_q;
    inflight_d   = inflight_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;

    if (dec_valid) begin
      hold_instr_d = dec_instr;
      hold_pc_d    = dec_pc;
    end else begin
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
    end

    if (redirect) begin
      // Flush: any pending response is dropped because inflight clears and
      // no request is issued in this cycle.
      st_d       = ST_RUN;
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
    end else begin
      if (imem_req) begin
        pc_d       = pc_q + ADDR_W'(1'b1);
        issue_pc_d = pc_q;
      end else begin
        pc_d       = pc_q;
        issue_pc_d = issue_pc_q;
      end
      inflight_d = imem_req;

      if (resp_halt) begin
        st_d = ST_HALT;
      end else begin
        st_d = st_q;
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q         <= ST_RUN;
      pc_q         <= {ADDR_W{1'b0}};
      issue_pc_q   <= {ADDR_W{1'b0}};
      inflight_q   <= 1'b0;
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      hold_instr_q <= {INSTR_W{1'b0}};
      hold_pc_q    <= {ADDR_W{1'b0}};
    end else begin
      st_q         <= st_d;
      pc_q         <= pc_d;
      issue_pc_q   <= issue_pc_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // FIFO storage; contents are only observed while count is non-zero, so no reset.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= issue_pc_q;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Scoreboard bench for pipeline_fetch_queue: directed phases push their
// expected {pc, instr} deliveries; a negedge monitor pops on every handshake.
module tb_pipeline_fetch_queue;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   imem_req;
  logic [ADDR_W-1:0]      imem_addr;
  logic [INSTR_W-1:0]     imem_rdata = 16'h0000;
  logic                   dec_valid;
  logic                   dec_ready;
  logic [INSTR_W-1:0]     dec_instr;
  logic [ADDR_W-1:0]      dec_pc;
  logic                   redirect;
  logic [ADDR_W-1:0]      redirect_pc;
  logic                   halted;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  exp_t               exp_q[$];
  logic [INSTR_W-1:0] mem [256];
  int                 n_cmp = 0;
  int                 n_err = 0;

  pipeline_fetch_queue #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted), .count(count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after a request.
  always @(posedge clk) begin
    if (imem_req === 1'b1) imem_rdata <= mem[imem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_out(input logic [ADDR_W-1:0] pc, input logic [INSTR_W-1:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got pc 0x%0h instr 0x%0h, expected none", dec_pc, dec_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("deliver_pc", 32'(dec_pc), 32'(e.pc));
        check("deliver_instr", 32'(dec_instr), 32'(e.instr));
      end
    end
  end

  initial begin
    reset       = 1'b0;
    dec_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h4000 | 16'(i);
    mem[0] = 16'h0A60;
    mem[1] = 16'h4C80;
    mem[2] = 16'hA0C0;
    mem[3] = 16'hC000;

    // Reset state
    repeat (3) step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_instr", 32'(dec_instr), 32'd0);
    check("rst_dec_pc", 32'(dec_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);

    // Sequential fetch into HALT at address 3
    expect_out(8'h00, 16'h0A60);
    expect_out(8'h01, 16'h4C80);
    expect_out(8'h02, 16'hA0C0);
    expect_out(8'h03, 16'hC000);
    reset = 1'b1;
    #1;
    check("c0_imem_req", 32'(imem_req), 32'd1);
    check("c0_imem_addr", 32'(imem_addr), 32'd0);
    step();
    check("c1_dec_valid", 32'(dec_valid), 32'd0);
    step();
    check("c2_dec_valid", 32'(dec_valid), 32'd1);
    check("c2_dec_pc", 32'(dec_pc), 32'd0);
    step();
    step();
    check("c4_no_issue_on_halt", 32'(imem_req), 32'd0);
    step();
    check("c5_halted", 32'(halted), 32'd1);
    check("c5_imem_req", 32'(imem_req), 32'd0);
    step();
    check("hold_dec_valid", 32'(dec_valid), 32'd0);
    check("hold_dec_pc", 32'(dec_pc), 32'h03);
    check("hold_dec_instr", 32'(dec_instr), 32'hC000);
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_imem_req", 32'(imem_req), 32'd0);
    end

    // Redirect out of HALT to 0xFE: PC wraps, then halts again at address 3
    expect_out(8'hFE, 16'h40FE);
    expect_out(8'hFF, 16'h40FF);
    expect_out(8'h00, 16'h0A60);
    expect_out(8'h01, 16'h4C80);
    expect_out(8'h02, 16'hA0C0);
    expect_out(8'h03, 16'hC000);
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    #1;
    check("redir_cycle_imem_req", 32'(imem_req), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check("wrap_halted_clear", 32'(halted), 32'd0);
    check("wrap_r1_count", 32'(count), 32'd0);
    check("wrap_r1_dec_valid", 32'(dec_valid), 32'd0);
    check("wrap_r1_imem_req", 32'(imem_req), 32'd1);
    check("wrap_r1_imem_addr", 32'(imem_addr), 32'hFE);
    step();
    check("wrap_r2_dec_valid", 32'(dec_valid), 32'd0);
    step();
    check("wrap_r3_dec_valid", 32'(dec_valid), 32'd1);
    check("wrap_r3_dec_pc", 32'(dec_pc), 32'hFE);
    repeat (8) step();
    check("wrap_rehalted", 32'(halted), 32'd1);
    check("wrap_drained", 32'(count), 32'd0);

    // Backpressure: redirect to 0x10 with decode stalled
    expect_out(8'h10, 16'h4010);
    expect_out(8'h11, 16'h4011);
    expect_out(8'h12, 16'h4012);
    expect_out(8'h13, 16'h4013);
    expect_out(8'h14, 16'h4014);
    expect_out(8'h15, 16'h4015);
    dec_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    step();
    redirect = 1'b0;
    repeat (9) step();
    check("bp_count_full", 32'(count), 32'd4);
    check("bp_imem_req", 32'(imem_req), 32'd0);
    check("bp_dec_valid", 32'(dec_valid), 32'd1);
    check("bp_head_pc", 32'(dec_pc), 32'h10);
    step();
    dec_ready = 1'b1;
    #1;
    check("bp_pop_no_issue", 32'(imem_req), 32'd0);
    step();
    check("bp_issue_after_pop", 32'(imem_req), 32'd1);
    check("bp_issue_addr", 32'(imem_addr), 32'h14);
    repeat (3) step();
    check("bp_p4_imem_req", 32'(imem_req), 32'd1);
    check("bp_p4_imem_addr", 32'(imem_addr), 32'h17);
    check("bp_p4_count", 32'(count), 32'd2);

    // Redirect to 0x20 while the 0x17 response is returning
    step();
    redirect    = 1'b1;
    redirect_pc = 8'h20;
    #1;
    check("kill_redir_imem_req", 32'(imem_req), 32'd0);
    check("kill_redir_pop_pc", 32'(dec_pc), 32'h15);
    step();
    redirect  = 1'b0;
    dec_ready = 1'b0;
    #1;
    check("kill_r1_count", 32'(count), 32'd0);
    check("kill_r1_dec_valid", 32'(dec_valid), 32'd0);
    check("kill_r1_imem_req", 32'(imem_req), 32'd1);
    check("kill_r1_imem_addr", 32'(imem_addr), 32'h20);
    step();
    check("kill_r2_dec_valid", 32'(dec_valid), 32'd0);
    step();
    check("kill_r3_dec_valid", 32'(dec_valid), 32'd1);
    check("kill_r3_dec_pc", 32'(dec_pc), 32'h20);
    check("kill_r3_dec_instr", 32'(dec_instr), 32'h4020);
    step();
    step();
    check("mid_count_before_reset", 32'(count), 32'd3);

    // Reset mid-stream for one cycle
    reset = 1'b0;
    step();
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_dec_valid", 32'(dec_valid), 32'd0);
    check("mid_rst_dec_instr", 32'(dec_instr), 32'd0);
    check("mid_rst_dec_pc", 32'(dec_pc), 32'd0);
    check("mid_rst_halted", 32'(halted), 32'd0);
    check("mid_rst_imem_req", 32'(imem_req), 32'd0);
    expect_out(8'h00, 16'h0A60);
    expect_out(8'h01, 16'h4C80);
    expect_out(8'h02, 16'hA0C0);
    expect_out(8'h03, 16'hC000);
    reset     = 1'b1;
    dec_ready = 1'b1;
    #1;
    check("post_rst_imem_req", 32'(imem_req), 32'd1);
    check("post_rst_imem_addr", 32'(imem_addr), 32'd0);
    repeat (10) step();
    check("post_rst_halted", 32'(halted), 32'd1);
    check("post_rst_dec_valid", 32'(dec_valid), 32'd0);

    // Every expected delivery must have been consumed
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_fetch_queue.md
# pipeline_fetch_queue

Instruction fetch front end for `pipeline_4_stage`. It generates the program counter, reads 16-bit instructions from a synchronous instruction memory, and buffers them with their PC in a small FIFO. It presents them to the decode stage over a valid/ready handshake, and supports redirect (flush) and halt on opcode `2'b11`. It sits directly upstream of the decode stage and replaces direct indexing of `instr_mem` by the core.

## Interface
Parameters:
- `ADDR_W`, default 8: PC and instruction-memory address width.
- `INSTR_W`, default 16: instruction width. Format is {op[1:0], rs1[2:0], rs2[2:0], rd[2:0], 5'b0}.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock. All state updates on its rising edge.
- `reset`, in, 1: reset, synchronous and active-low. State clears on a rising edge where `reset`==0.
- `imem_req`, out, 1: read request to instruction memory this cycle.
- `imem_addr`, out, ADDR_W: read address, equal to `pc`.
- `imem_rdata`, in, INSTR_W: read data, valid in the cycle after an accepted `imem_req`.
- `dec_valid`, out, 1: FIFO head holds an instruction.
- `dec_ready`, in, 1: decode accepts the head this cycle.
- `dec_instr`, out, INSTR_W: head instruction.
- `dec_pc`, out, ADDR_W: PC of the head instruction.
- `redirect`, in, 1: flush and restart fetch.
- `redirect_pc`, in, ADDR_W: new fetch address, sampled when `redirect`==1.
- `halted`, out, 1: fetch is stopped after a HALT instruction.
- `count`, out, $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- State register `st` has two states: RUN and HALT. `halted` = (`st`==HALT).
- Occupancy accounting:
  - `inflight` is a 1-bit flag set the cycle after an issued request and cleared when its data is written or killed.
  - Issue condition: `imem_req` = (`st`==RUN) && !`redirect` && (`count` + `inflight` < DEPTH). This is combinational.
  - A pop in the same cycle does not free space for that cycle's issue decision.
- On issue, `pc` <= `pc` + 1, modulo 2^ADDR_W; 255 wraps to 0 for ADDR_W=8.
- Response cycle (`inflight`==1, not killed): push {`imem_rdata`, issued PC} into the FIFO.
  - If `imem_rdata`[15:14]==2'b11, `st` <= HALT. The HALT word itself is enqueued and delivered to decode.
  - No further issue occurs in HALT.
- Pop occurs when `dec_valid` && `dec_ready`. Push and pop in the same cycle leave `count` unchanged.
- `dec_valid` = (`count` != 0). `dec_instr`/`dec_pc` are driven from the head entry. When `count`==0 they hold their last value, or 0 after reset.
- Redirect (priority over everything except reset):
  - A pop handshake in the same cycle still completes; the consumer has taken that instruction.
  - At the edge, the FIFO empties (`count` <= 0, pointers reset), `pc` <= `redirect_pc`, and `st` <= RUN.
  - Any in-flight response is killed: the data returning next cycle is discarded. A redirect arriving in a response cycle discards that response.
  - No `imem_req` is issued in the redirect cycle. Fetch from `redirect_pc` begins the following cycle.
- A redirect while in HALT restarts fetch. HALT is exited only by redirect or reset.
- Overflow is impossible by construction. No push occurs when `count`==DEPTH.

## Timing
- Reset values: `pc`=0, `st`=RUN, `inflight`=0, `count`=0, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0, `halted`=0. `imem_req`=0 while `reset`==0.
- First request goes out in the first cycle with `reset`==1, at address 0.
- Latency: request in cycle N → data pushed at the end of N+1 → `dec_valid` high in N+2 (2 cycles).
- Throughput is 1 instruction/cycle with `dec_ready` held high.
- Redirect asserted in cycle R → first request to `redirect_pc` in R+1 → that instruction's `dec_valid` in R+3. `dec_valid`=0 in R+1 and R+2.
- Reset asserted mid-operation applies on the next edge: FIFO contents and in-flight data are dropped, and the `imem_rdata` returning after reset is ignored.
- Backpressure: with `dec_ready`=0, the FIFO fills to DEPTH and `imem_req` stays 0 until a pop. The first issue after the pop occurs in the cycle after the pop.

## Test plan
- Sequential fetch: program ADD(0x0A60), SUB(0x4C80), LOAD(0xA0C0) at addresses 0-2, `dec_ready`=1 → `dec_valid` first high in cycle 2 after reset release; `dec_pc`=0,1,2 on consecutive cycles with matching words.
- Backpressure: `dec_ready`=0 for 10 cycles → `count` reaches 4 and `imem_req`=0. Release `dec_ready` → words delivered in order with no loss and no duplicate.
- Redirect with in-flight data: assert `redirect`, `redirect_pc`=0x20 while a request is outstanding → `count`=0 next cycle, stale word never appears, next `dec_pc`=0x20 three cycles later.
- Halt: word 0xC000 at address 3 → addresses 0-3 delivered, `halted`=1, no `imem_req` after the address-3 request. A redirect to 0 resumes fetch.
- PC wrap: redirect to 0xFE → `dec_pc` sequence 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-stream: drive `reset`=0 for 1 cycle with `count`=3 → all outputs take their reset values, and the first post-reset `dec_pc`=0.
